// File: rtl/packet_flit_tx.sv
// packet_flit_tx: queues 64-bit reduction packets in a FIFO and serializes them onto a 16-bit flit link.
// Define PKT_FLIT_CHECKSUM_EN to append an XOR checksum flit after the data flits of every packet.
module packet_flit_tx #(
    parameter int DataWidth = 64,
    parameter int FlitWidth = 16,
    parameter int FifoDepth = 4,
    parameter int CntWidth  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DataWidth-1:0]        pktIn,
    input  logic                        pktInValid,
    output logic                        pktInReady,
    output logic [FlitWidth-1:0]        flitOut,
    output logic                        flitValid,
    input  logic                        flitReady,
    output logic                        flitLast,
    output logic [$clog2(FifoDepth):0]  occupancy,
    output logic [CntWidth-1:0]         dropCount
);
    localparam int PtrW    = $clog2(FifoDepth);
    localparam int CountW  = PtrW + 1;
    localparam int NumData = DataWidth / FlitWidth;
`ifdef PKT_FLIT_CHECKSUM_EN
    localparam int LastIdx = NumData;
`else
    localparam int LastIdx = NumData - 1;
`endif
    localparam int IdxW    = $clog2(LastIdx + 1);

    typedef enum logic {IDLE, SEND} state_t;

    // Flit i of packet p, most significant slice first; index NumData is the XOR checksum when enabled.
    function automatic logic [FlitWidth-1:0] flit_of(input logic [DataWidth-1:0] p, input logic [IdxW-1:0] i);
        logic [FlitWidth-1:0] f;
        f = '0;
        for (int k = 0; k < NumData; k++) begin
`ifdef PKT_FLIT_CHECKSUM_EN
            if (i == IdxW'(NumData)) f = f ^ p[DataWidth-1-k*FlitWidth -: FlitWidth];
`endif
            if (i == IdxW'(k)) f = p[DataWidth-1-k*FlitWidth -: FlitWidth];
        end
        return f;
    endfunction

    logic [DataWidth-1:0] mem_q [FifoDepth];
    logic [PtrW-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [CountW-1:0]    count_q, count_d;
    logic [CntWidth-1:0]  drop_q, drop_d;
    state_t               state_q, state_d;
    logic [DataWidth-1:0] hold_q, hold_d;
    logic [IdxW-1:0]      idx_q, idx_d, idx_nxt;
    logic [FlitWidth-1:0] flit_q, flit_d;
    logic                 valid_q, valid_d, last_q, last_d;
    logic                 push, drop_pkt, fire, done, pop;

    assign pktInReady = rst_n && (count_q != CountW'(FifoDepth));
    assign push       = pktInValid && pktInReady && pktIn[DataWidth-1];
    assign drop_pkt   = pktInValid && pktInReady && !pktIn[DataWidth-1];
    assign fire       = valid_q && flitReady;
    assign done       = fire && (idx_q == IdxW'(LastIdx));
    assign pop        = (count_q != '0) && (state_q == IDLE || done);
    assign idx_nxt    = idx_q + IdxW'(1);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        flit_d  = flit_q;
        valid_d = valid_q;
        last_d  = last_q;
        wr_d    = push ? wr_q + PtrW'(1) : wr_q;
        rd_d    = pop ? rd_q + PtrW'(1) : rd_q;
        count_d = count_q + CountW'(push) - CountW'(pop);
        drop_d  = (drop_pkt && drop_q != '1) ? drop_q + CntWidth'(1) : drop_q;
        if (pop) begin
            state_d = SEND;
            hold_d  = mem_q[rd_q];
            idx_d   = '0;
            flit_d  = flit_of(mem_q[rd_q], '0);
            valid_d = 1'b1;
            last_d  = 1'b0;
        end else if (done) begin
            state_d = IDLE;
            flit_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else if (fire) begin
            idx_d   = idx_nxt;
            flit_d  = flit_of(hold_q, idx_nxt);
            last_d  = (idx_nxt == IdxW'(LastIdx));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= pktIn;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
            flit_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            flit_q  <= flit_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    assign flitOut   = flit_q;
    assign flitValid = valid_q;
    assign flitLast  = last_q;
    assign occupancy = count_q;
    assign dropCount = drop_q;
endmodule

// File: doc/packet_flit_tx.md
Name: packet_flit_tx

Overview:
- Downstream of the reduction packet builder: accepts complete 64-bit reduction packets and queues them in a small FIFO.
- Serializes each packet onto a narrow 16-bit link as flits, header flit first, under a valid/ready handshake.
- Discards packets whose valid bit (63) is clear and counts them.
- Sits between the packet builder and the network-side link interface.

Parameters:
- DataWidth, 64, packet width in bits; fixed, do not override.
- FlitWidth, 16, link flit width; DataWidth/FlitWidth = 4 flits per packet.
- FifoDepth, 4, packet FIFO entries; must be a power of 2, minimum 2.
- CntWidth, 8, width of dropped-packet counter.

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- pktIn  input  64  packet from packet builder (bit 63 valid, bit 62 reduction, 61-59 src, 58-56 dst, 31-0 payload).
- pktInValid  input  1  pktIn is offered this cycle.
- pktInReady  output  1  block can accept pktIn this cycle.
- flitOut  output  16  current outbound flit.
- flitValid  output  1  flitOut holds a valid flit.
- flitReady  input  1  link consumes flitOut this cycle.
- flitLast  output  1  flitOut is the final flit of its packet.
- occupancy  output  log2(FifoDepth)+1  packets queued in the FIFO, excluding any packet in the serializer.
- dropCount  output  CntWidth  packets discarded for a clear valid bit; saturates.

Behaviour:
- Reset (rst_n low, asynchronous):
  - flitOut=0, flitValid=0, flitLast=0, occupancy=0, dropCount=0.
  - FIFO pointers 0; FSM to IDLE.
  - pktInReady forced 0 while rst_n is low; it rises the first cycle after deassertion.
- Input acceptance:
  - pktInReady = (occupancy != FifoDepth), combinational from registered count.
  - No push-when-full bypass: when full, pktInReady=0 even if a pop occurs in the same cycle.
  - On pktInValid && pktInReady:
    - if pktIn[63]=1, write to FIFO at wrPtr; wrPtr wraps modulo FifoDepth.
    - if pktIn[63]=0, no write; dropCount += 1, saturating at all-ones.
- Occupancy: +1 on valid-packet push, -1 on pop, unchanged when both occur in the same cycle.
- FSM states: IDLE, SEND.
  - IDLE: if occupancy>0, load FIFO head into a 64-bit holding register, pop (rdPtr wraps), flitIdx=0, set flitValid=1, go SEND.
  - SEND: flit order is flitIdx 0 = bits[63:48], 1 = [47:32], 2 = [31:16], 3 = [15:0]. flitLast=1 only at flitIdx 3.
  - SEND, on flitValid && flitReady: flitIdx += 1.
  - SEND, handshake on the last flit: if occupancy>0, load the next packet in the same edge (no bubble, flitIdx=0, stay SEND); else flitValid=0, flitLast=0, go IDLE.
- Stability: while flitValid && !flitReady, flitOut and flitLast hold constant.
- Latency: valid packet accepted at edge T into an empty block → FIFO write at T, serializer load at T+1, flit0 on flitOut with flitValid=1 after T+1. With a continuously ready link, 4 flits occupy cycles T+1..T+4.
- Throughput: 1 flit/cycle; back-to-back packets have no idle flit.
- Reset mid-packet: partial packet and all FIFO contents are lost; no flit is emitted until a new packet arrives, starting at flit 0.

Optional Feature:
- Macro PKT_FLIT_CHECKSUM_EN.
- Defined: a 5th flit (flitIdx 4) equal to the XOR of the 4 data flits follows flit 3; flitLast moves to flitIdx 4; 5 flits per packet.
- Undefined: 4 flits per packet, flitLast on flitIdx 3, no checksum logic.

Test Plan:
- Single packet 0xC123_4567_89AB_CDEF, flitReady=1:
  - flits C123, 4567, 89AB, CDEF on consecutive cycles; flitLast only on CDEF; flitValid=0 afterward.
  - With PKT_FLIT_CHECKSUM_EN, a 5th flit C000 with flitLast=1.
- Backpressure: same packet, flitReady=0 for 3 cycles while flit 4567 is shown → flitOut stays 4567 with flitValid=1; 89AB follows one cycle after flitReady returns to 1.
- Fill: flitReady=0, offer 5 valid packets on consecutive cycles:
  - packet 1 is in the serializer; occupancy reaches 4 and pktInReady=0.
  - Release flitReady=1: 20 contiguous flits with no bubble; occupancy decrements after each packet's last flit.
- Drop: offer 0x4000_0000_0000_0001 (bit 63 clear) → pktInReady stays 1, no flits, dropCount=1. After 300 such packets, dropCount=255.
- Reset mid-packet: assert rst_n=0 after flit 4567 is accepted, with 2 packets queued:
  - outputs go to 0 immediately and occupancy=0.
  - After release, new packet 0x8000_0000_0000_00AA emits 8000, 0000, 0000, 00AA.
